// File: rtl/bram_tdp_lanes.sv
// True-dual-port single-clock block RAM with per-lane write enables and per-port write modes.
// It has selectable read latency, deterministic same-address collision resolution and a saturating collision counter.
module bram_tdp_lanes #(
    parameter int LANES    = 2,
    parameter int LANE_W   = 9,
    parameter int ADDR_W   = 9,
    parameter int READ_LAT = 1,
    parameter int WMODE_A  = 0,
    parameter int WMODE_B  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [LANES-1:0]        wea,
    input  logic [ADDR_W-1:0]       addra,
    input  logic [LANES*LANE_W-1:0] dia,
    input  logic                    ssra,
    output logic [LANES*LANE_W-1:0] doa,
    output logic                    doa_vld,
    input  logic                    enb,
    input  logic [LANES-1:0]        web,
    input  logic [ADDR_W-1:0]       addrb,
    input  logic [LANES*LANE_W-1:0] dib,
    input  logic                    ssrb,
    output logic [LANES*LANE_W-1:0] dob,
    output logic                    dob_vld,
    output logic                    coll,
    output logic [15:0]             coll_cnt
);

    localparam int W     = LANES * LANE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic [W-1:0]     mem [DEPTH];

    logic [LANES-1:0] wr_a;
    logic [LANES-1:0] wr_b;
    logic             coll_now;
    logic [W-1:0]     old_a;
    logic [W-1:0]     old_b;
    logic [W-1:0]     nxt_a;
    logic [W-1:0]     nxt_b;
    logic             hold_a;
    logic             hold_b;

    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic             v1_a;
    logic             v1_b;

    always_comb begin
        wr_a     = (ena && !rst) ? wea : '0;
        wr_b     = (enb && !rst) ? web : '0;
        coll_now = ena && enb && (addra == addrb) && ((|wea) || (|web));
        old_a    = mem[addra];
        old_b    = mem[addrb];
    end

    // Port B is written first so that port A wins any same-lane write-write collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_b[i]) begin
                mem[addrb][i*LANE_W +: LANE_W] <= dib[i*LANE_W +: LANE_W];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (wr_a[i]) begin
                mem[addra][i*LANE_W +: LANE_W] <= dia[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read data is built from the pre-write word, so lanes written only by the other
    // port always read old; only the port's own written lanes can show new data.
    always_comb begin
        nxt_a  = old_a;
        nxt_b  = old_b;
        hold_a = (WMODE_A == 2) && (|wea);
        hold_b = (WMODE_B == 2) && (|web);
        for (int i = 0; i < LANES; i++) begin
            if (WMODE_A == 0 && wea[i]) begin
                nxt_a[i*LANE_W +: LANE_W] = dia[i*LANE_W +: LANE_W];
            end
            if (WMODE_B == 0 && web[i]) begin
                if (coll_now && ena && wea[i]) begin
                    nxt_b[i*LANE_W +: LANE_W] = dia[i*LANE_W +: LANE_W];
                end else begin
                    nxt_b[i*LANE_W +: LANE_W] = dib[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a <= '0;
            v1_a <= 1'b0;
        end else begin
            v1_a <= ena;
            if (ena) begin
                if (ssra) begin
                    s1_a <= '0;
                end else if (!hold_a) begin
                    s1_a <= nxt_a;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_b <= '0;
            v1_b <= 1'b0;
        end else begin
            v1_b <= enb;
            if (enb) begin
                if (ssrb) begin
                    s1_b <= '0;
                end else if (!hold_b) begin
                    s1_b <= nxt_b;
                end
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [W-1:0] s2_a;
            logic [W-1:0] s2_b;
            logic         v2_a;
            logic         v2_b;

            // The output register only advances behind a valid stage-1 access, so idle cycles hold it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_a <= '0;
                    s2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) begin
                        s2_a <= s1_a;
                    end
                    if (v1_b) begin
                        s2_b <= s1_b;
                    end
                end
            end

            assign doa     = s2_a;
            assign doa_vld = v2_a;
            assign dob     = s2_b;
            assign dob_vld = v2_b;
        end else begin : g_lat1
            assign doa     = s1_a;
            assign doa_vld = v1_a;
            assign dob     = s1_b;
            assign dob_vld = v1_b;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            coll     <= 1'b0;
            coll_cnt <= 16'h0000;
        end else begin
            coll <= coll_now;
            if (coll_now && coll_cnt != 16'hFFFF) begin
                coll_cnt <= coll_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bram_tdp_lanes.sv
// Directed bench for bram_tdp_lanes: two instances share one stimulus stream.
// Instance 1 is latency 1 with A=WRITE_FIRST and B=READ_FIRST; instance 2 is latency 2 with A=WRITE_FIRST and B=NO_CHANGE.
module tb_bram_tdp_lanes;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [1:0]  wea;
    logic [8:0]  addra;
    logic [17:0] dia;
    logic        ssra;
    logic        enb;
    logic [1:0]  web;
    logic [8:0]  addrb;
    logic [17:0] dib;
    logic        ssrb;

    logic [17:0] doa1, dob1, doa2, dob2;
    logic        doa1_vld, dob1_vld, doa2_vld, dob2_vld;
    logic        coll1, coll2;
    logic [15:0] coll_cnt1, coll_cnt2;

    int vectors;
    int miscompares;

    bram_tdp_lanes #(.LANES(2), .LANE_W(9), .ADDR_W(9), .READ_LAT(1), .WMODE_A(0), .WMODE_B(1)) dut1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .ssra(ssra), .doa(doa1), .doa_vld(doa1_vld),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib), .ssrb(ssrb), .dob(dob1), .dob_vld(dob1_vld),
        .coll(coll1), .coll_cnt(coll_cnt1)
    );

    bram_tdp_lanes #(.LANES(2), .LANE_W(9), .ADDR_W(9), .READ_LAT(2), .WMODE_A(0), .WMODE_B(2)) dut2 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .ssra(ssra), .doa(doa2), .doa_vld(doa2_vld),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib), .ssrb(ssrb), .dob(dob2), .dob_vld(dob2_vld),
        .coll(coll2), .coll_cnt(coll_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of both ports, then waits until just after the sampling edge.
    task automatic applyStimulus(input logic a_en, input logic [1:0] a_we, input logic [8:0] a_addr,
                                 input logic [17:0] a_di, input logic a_ssr,
                                 input logic b_en, input logic [1:0] b_we, input logic [8:0] b_addr,
                                 input logic [17:0] b_di, input logic b_ssr);
        ena = a_en; wea = a_we; addra = a_addr; dia = a_di; ssra = a_ssr;
        enb = b_en; web = b_we; addrb = b_addr; dib = b_di; ssrb = b_ssr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] lane_word(input int i);
        logic [8:0] hi;
        logic [8:0] lo;
        hi = 9'h100 + 9'(i);
        lo = 9'h040 + 9'(i);
        return {hi, lo};
    endfunction

    int seq [9];
    int prev;
    int cur;
    logic [8:0] a9;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        ena = 0; wea = 0; addra = 0; dia = 0; ssra = 0;
        enb = 0; web = 0; addrb = 0; dib = 0; ssrb = 0;

        // Reset state
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("rst_doa", doa1, 18'h0);
        checkOutput("rst_doa_vld", doa1_vld, 1'b0);
        checkOutput("rst_coll", coll1, 1'b0);
        checkOutput("rst_coll_cnt", coll_cnt1, 16'h0);
        rst = 1'b0;

        // T1: contents survive reset, writes under reset are dropped
        applyStimulus(1, 2'b11, 9'd5, {9'h1FF, 9'h0AA}, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t1_wf_doa", doa1, {9'h1FF, 9'h0AA});
        checkOutput("t1_wf_vld", doa1_vld, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1, 2'b00, 9'd5, 0, 0, 1, 2'b11, 9'd5, 18'h0, 0);
        checkOutput("t1_rst_doa", doa1, 18'h0);
        checkOutput("t1_rst_vld", doa1_vld, 1'b0);
        checkOutput("t1_rst_coll", coll1, 1'b0);
        checkOutput("t1_rst_cnt", coll_cnt1, 16'h0);
        rst = 1'b0;
        applyStimulus(1, 2'b00, 9'd5, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t1_read_doa", doa1, {9'h1FF, 9'h0AA});
        checkOutput("t1_read_vld", doa1_vld, 1'b1);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t1_hold_doa", doa1, {9'h1FF, 9'h0AA});
        checkOutput("t1_idle_vld", doa1_vld, 1'b0);
        checkOutput("t1_lat2_doa", doa2, {9'h1FF, 9'h0AA});
        checkOutput("t1_lat2_vld", doa2_vld, 1'b1);

        // T2: lane masks, WRITE_FIRST on A, READ_FIRST on B
        applyStimulus(1, 2'b11, 9'd3, {9'h111, 9'h022}, 0, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 2'b01, 9'd3, {9'h1FF, 9'h0CC}, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t2_wf_mask", doa1, {9'h111, 9'h0CC});
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 2'b10, 9'd3, {9'h1EE, 9'h0DD}, 0);
        checkOutput("t2_rf_old", dob1, {9'h111, 9'h0CC});
        applyStimulus(1, 2'b00, 9'd3, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t2_stored", doa1, {9'h1EE, 9'h0CC});

        // T3: latency-2 streaming on port B with a one-cycle gap
        for (int i = 0; i < 8; i++) begin
            a9 = 9'(i);
            applyStimulus(1, 2'b11, a9, lane_word(i), 0, 0, 2'b00, 0, 0, 0);
        end
        seq = '{0, 1, 2, -1, 3, 4, 5, 6, 7};
        prev = -1;
        for (int k = 0; k < 11; k++) begin
            cur = (k < 9) ? seq[k] : -1;
            if (cur >= 0) begin
                a9 = 9'(cur);
                applyStimulus(0, 2'b00, 0, 0, 0, 1, 2'b00, a9, 0, 0);
            end else begin
                applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
            end
            checkOutput("t3_vld", dob2_vld, (prev >= 0) ? 1'b1 : 1'b0);
            if (prev >= 0) checkOutput("t3_dob", dob2, lane_word(prev));
            prev = cur;
        end

        // T4: collisions
        applyStimulus(1, 2'b11, 9'd10, {9'h0AB, 9'h0CD}, 0, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 2'b11, 9'd10, {9'h001, 9'h002}, 0, 1, 2'b10, 9'd10, {9'h1F0, 9'h1F1}, 0);
        checkOutput("t4_coll", coll1, 1'b1);
        checkOutput("t4_cnt1", coll_cnt1, 16'd1);
        checkOutput("t4_doa_wf", doa1, {9'h001, 9'h002});
        checkOutput("t4_dob_old", dob1, {9'h0AB, 9'h0CD});
        applyStimulus(1, 2'b00, 9'd10, 0, 0, 1, 2'b01, 9'd10, {9'h000, 9'h1F1}, 0);
        checkOutput("t4_coll2", coll1, 1'b1);
        checkOutput("t4_cnt2", coll_cnt1, 16'd2);
        checkOutput("t4_cross_old", doa1, {9'h001, 9'h002});
        applyStimulus(1, 2'b00, 9'd10, 0, 0, 1, 2'b00, 9'd10, 0, 0);
        checkOutput("t4_rr_coll", coll1, 1'b0);
        checkOutput("t4_rr_cnt", coll_cnt1, 16'd2);
        checkOutput("t4_rr_doa", doa1, {9'h001, 9'h1F1});
        checkOutput("t4_rr_dob", dob1, {9'h001, 9'h1F1});

        // T5: NO_CHANGE and SSR
        applyStimulus(1, 2'b11, 9'd4, {9'h055, 9'h055}, 0, 0, 2'b00, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 2'b00, 9'd4, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 2'b11, 9'd4, {9'h0AA, 9'h0BB}, 0);
        checkOutput("t5_read", dob2, {9'h055, 9'h055});
        checkOutput("t5_rf_dob1", dob1, {9'h055, 9'h055});
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t5_nc_hold", dob2, {9'h055, 9'h055});
        checkOutput("t5_nc_vld", dob2_vld, 1'b1);
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 2'b01, 9'd4, {9'h000, 9'h1CC}, 1);
        checkOutput("t5_ssr_dob", dob1, 18'h0);
        checkOutput("t5_ssr_vld", dob1_vld, 1'b1);
        applyStimulus(1, 2'b00, 9'd4, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t5_ssr_write", doa1, {9'h0AA, 9'h1CC});
        checkOutput("t5_ssr_lat2", dob2, 18'h0);
        checkOutput("t5_ssr_lat2_vld", dob2_vld, 1'b1);
        checkOutput("t5_idle_vld", dob1_vld, 1'b0);

        // T6: counter saturation
        rst = 1'b1;
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        for (int n = 0; n < 65534; n++) applyStimulus(1, 2'b01, 9'd20, 18'h1, 0, 1, 2'b00, 9'd20, 0, 0);
        checkOutput("t6_cnt_fffe", coll_cnt1, 16'hFFFE);
        for (int n = 0; n < 3; n++) applyStimulus(1, 2'b01, 9'd20, 18'h1, 0, 1, 2'b00, 9'd20, 0, 0);
        checkOutput("t6_coll", coll1, 1'b1);
        checkOutput("t6_sat", coll_cnt1, 16'hFFFF);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        checkOutput("t6_coll_end", coll1, 1'b0);
        checkOutput("t6_sat_hold", coll_cnt1, 16'hFFFF);
        checkOutput("t6_sat_dut2", coll_cnt2, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
